// File: rtl/memory_stage.sv
// memory_stage: Y86-64 pipeline memory stage including the E->M register.
//
// Ports:
//   clk, reset                 pipeline clock, synchronous active-high reset
//   m_stall, m_bubble          hold / bubble controls for the M register
//   e_icode .. e_in_inst       execute results and E-register fields to latch
//   M_icode .. M_dstM          latched M-register fields (M_dstE is cond-masked)
//   m_valM                     combinational data-memory read result
//   m_stat                     stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   m_err                      sticky flag, set once a non-AOK status retires
//
// The data memory is internal, byte-addressed and little-endian. It is
// accessed one 8-byte word at a time, at any byte offset.
module memory_stage #(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_stall,
  input  logic              m_bubble,
  input  logic [3:0]        e_icode,
  input  logic              e_cond,
  input  logic [ADDR_W-1:0] e_valE,
  input  logic [ADDR_W-1:0] e_valA,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        e_dstM,
  input  logic              e_hlt,
  input  logic              e_in_mem,
  input  logic              e_in_inst,
  output logic [3:0]        M_icode,
  output logic              M_cond,
  output logic [ADDR_W-1:0] M_valE,
  output logic [ADDR_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM,
  output logic [ADDR_W-1:0] m_valM,
  output logic [2:0]        m_stat,
  output logic              m_err
);

  localparam int unsigned IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 8);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  // M pipeline register
  logic [3:0]        icode_q, icode_d;
  logic              cond_q, cond_d;
  logic [ADDR_W-1:0] valE_q, valE_d;
  logic [ADDR_W-1:0] valA_q, valA_d;
  logic [3:0]        dstE_q, dstE_d;
  logic [3:0]        dstM_q, dstM_d;
  logic [2:0]        stat_q, stat_d;
  logic              err_q, err_d;

  // Memory access decode
  logic              rd_en, wr_en, addr_ok, mem_we;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        mem_rd [MEM_BYTES];

  always_comb begin
    icode_d = icode_q;
    cond_d  = cond_q;
    valE_d  = valE_q;
    valA_d  = valA_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    stat_d  = stat_q;
    if (m_bubble) begin
      icode_d = I_NOP;
      cond_d  = 1'b0;
      valE_d  = '0;
      valA_d  = '0;
      dstE_d  = R_NONE;
      dstM_d  = R_NONE;
      stat_d  = STAT_AOK;
    end else if (!m_stall) begin
      icode_d = e_icode;
      cond_d  = e_cond;
      valE_d  = e_valE;
      valA_d  = e_valA;
      dstE_d  = (e_icode == I_CMOV && !e_cond) ? R_NONE : e_dstE;
      dstM_d  = e_dstM;
      if (e_hlt)          stat_d = STAT_HLT;
      else if (e_in_mem)  stat_d = STAT_ADR;
      else if (e_in_inst) stat_d = STAT_INS;
      else                stat_d = STAT_AOK;
    end
  end

  always_comb begin
    rd_en   = (icode_q == I_MRMOVQ) || (icode_q == I_POPQ) || (icode_q == I_RET);
    wr_en   = (icode_q == I_RMMOVQ) || (icode_q == I_PUSHQ) || (icode_q == I_CALL);
    addr    = (icode_q == I_POPQ || icode_q == I_RET) ? valA_q : valE_q;
    addr_ok = (addr <= ADDR_MAX);
    idx     = addr[IDX_W-1:0];
    // A carried HLT/INS outranks the address fault.
    if ((rd_en || wr_en) && !addr_ok && stat_q == STAT_AOK) m_stat = STAT_ADR;
    else                                                    m_stat = stat_q;
    mem_we  = wr_en && addr_ok && (stat_q == STAT_AOK) && !m_stall && !reset;
    err_d   = err_q || ((m_stat != STAT_AOK) && !m_stall);
  end

  always_comb begin
    m_valM = '0;
    if (rd_en && addr_ok) begin
      for (int unsigned i = 0; i < 8; i++) begin
        m_valM[i*8 +: 8] = mem_rd[idx + IDX_W'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icode_q <= I_NOP;
      cond_q  <= 1'b0;
      valE_q  <= '0;
      valA_q  <= '0;
      dstE_q  <= R_NONE;
      dstM_q  <= R_NONE;
      stat_q  <= STAT_AOK;
      err_q   <= 1'b0;
    end else begin
      icode_q <= icode_d;
      cond_q  <= cond_d;
      valE_q  <= valE_d;
      valA_q  <= valA_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      stat_q  <= stat_d;
      err_q   <= err_d;
    end
  end

  // Each byte owns its flop; it is written when it falls inside the 8-byte
  // window starting at the write address (off = b - addr, modulo 2^IDX_W).
  for (genvar b = 0; b < MEM_BYTES; b++) begin : g_byte
    logic [7:0]       byte_q, byte_d;
    logic [IDX_W-1:0] off;

    always_comb begin
      off    = IDX_W'(b) - idx;
      byte_d = byte_q;
      if (mem_we && off < IDX_W'(8)) byte_d = valA_q[{off[2:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
      if (reset) byte_q <= '0;
      else       byte_q <= byte_d;
    end

    assign mem_rd[b] = byte_q;
  end

  assign M_icode = icode_q;
  assign M_cond  = cond_q;
  assign M_valE  = valE_q;
  assign M_valA  = valA_q;
  assign M_dstE  = dstE_q;
  assign M_dstM  = dstM_q;
  assign m_err   = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scoreboard bench for memory_stage.
// Expected values are queued alongside each stimulus step and compared
// one clock edge later, once the M register has taken the step.
module tb_memory_stage;

  localparam int unsigned MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        reset, m_stall, m_bubble;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic        e_cond, e_hlt, e_in_mem, e_in_inst;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_cond, m_err;
  logic [63:0] M_valE, M_valA, m_valM;
  logic [2:0]  m_stat;

  int checks = 0;
  int errors = 0;

  string       tag_q [$];
  int          sel_q [$];
  logic [63:0] exp_q [$];

  localparam int S_ICODE = 0, S_COND = 1, S_VALE = 2, S_VALA = 3, S_DSTE = 4,
                 S_DSTM = 5, S_VALM = 6, S_STAT = 7, S_ERR = 8;

  memory_stage #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .m_stall(m_stall), .m_bubble(m_bubble),
    .e_icode(e_icode), .e_cond(e_cond), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_hlt(e_hlt), .e_in_mem(e_in_mem),
    .e_in_inst(e_in_inst), .M_icode(M_icode), .M_cond(M_cond),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_valM(m_valM), .m_stat(m_stat), .m_err(m_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      S_ICODE: obs = {60'd0, M_icode};
      S_COND:  obs = {63'd0, M_cond};
      S_VALE:  obs = M_valE;
      S_VALA:  obs = M_valA;
      S_DSTE:  obs = {60'd0, M_dstE};
      S_DSTM:  obs = {60'd0, M_dstM};
      S_VALM:  obs = m_valM;
      S_STAT:  obs = {61'd0, m_stat};
      default: obs = {63'd0, m_err};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [63:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  // Advance one edge, then drain the scoreboard against the DUT outputs.
  task automatic step();
    string       t;
    int          s;
    logic [63:0] e, o;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      o = obs(s);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic c, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    e_icode = ic; e_cond = c; e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
  endtask

  initial begin
    reset = 1'b1; m_stall = 1'b0; m_bubble = 1'b0;
    e_hlt = 1'b0; e_in_mem = 1'b0; e_in_inst = 1'b0;
    drive(4'h4, 1'b1, 64'h55, 64'h66, 4'h2, 4'h3);

    // Reset for two cycles
    step();
    expect_val("rst_icode", S_ICODE, 64'h1);
    expect_val("rst_dstE",  S_DSTE,  64'hF);
    expect_val("rst_dstM",  S_DSTM,  64'hF);
    expect_val("rst_stat",  S_STAT,  64'h1);
    expect_val("rst_err",   S_ERR,   64'h0);
    expect_val("rst_valA",  S_VALA,  64'h0);
    step();
    reset = 1'b0;

    drive(4'h5, 1'b0, 64'h0, 64'h0, 4'hF, 4'h1);
    expect_val("rd0_valM", S_VALM, 64'h0);
    expect_val("rd0_stat", S_STAT, 64'h1);
    step();

    // rmmovq then two reads, aligned and unaligned
    drive(4'h4, 1'b0, 64'h10, 64'h1122334455667788, 4'hF, 4'hF);
    expect_val("rmmov_icode", S_ICODE, 64'h4);
    expect_val("rmmov_valM",  S_VALM,  64'h0);
    step();
    drive(4'h5, 1'b0, 64'h10, 64'h0, 4'hF, 4'h3);
    expect_val("mrmov10_valM", S_VALM, 64'h1122334455667788);
    expect_val("mrmov10_dstM", S_DSTM, 64'h3);
    step();
    drive(4'h5, 1'b0, 64'h13, 64'h0, 4'hF, 4'h3);
    expect_val("mrmov13_valM", S_VALM, 64'h0000001122334455);
    step();

    // cmov masking
    drive(4'h2, 1'b0, 64'h77, 64'h0, 4'h5, 4'hF);
    expect_val("cmov0_dstE", S_DSTE, 64'hF);
    expect_val("cmov0_cond", S_COND, 64'h0);
    step();
    drive(4'h2, 1'b1, 64'h1234, 64'h0, 4'h5, 4'hF);
    expect_val("cmov1_dstE", S_DSTE, 64'h5);
    expect_val("cmov1_valE", S_VALE, 64'h1234);
    expect_val("cmov1_cond", S_COND, 64'h1);
    step();

    // Out-of-range pushq, then popq at the last valid word
    drive(4'hA, 1'b0, 64'(MEM_BYTES - 7), 64'hDEAD, 4'h4, 4'hF);
    expect_val("push_oob_stat", S_STAT, 64'h3);
    expect_val("push_oob_err",  S_ERR,  64'h0);
    step();
    drive(4'hB, 1'b0, 64'(MEM_BYTES), 64'(MEM_BYTES - 8), 4'h4, 4'h4);
    expect_val("pop_last_stat", S_STAT, 64'h1);
    expect_val("pop_last_valM", S_VALM, 64'h0);
    expect_val("pop_last_dstM", S_DSTM, 64'h4);
    expect_val("err_sticky",    S_ERR,  64'h1);
    step();

    // Valid write to the last word, read back
    drive(4'hA, 1'b0, 64'(MEM_BYTES - 8), 64'h0102030405060708, 4'h4, 4'hF);
    expect_val("push_last_stat", S_STAT, 64'h1);
    step();
    drive(4'hB, 1'b0, 64'(MEM_BYTES), 64'(MEM_BYTES - 8), 4'h4, 4'h4);
    expect_val("pop_last2_valM", S_VALM, 64'h0102030405060708);
    step();

    // Negative address and carried INS with a bad address
    drive(4'h5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 4'hF, 4'h2);
    expect_val("neg_stat", S_STAT, 64'h3);
    expect_val("neg_valM", S_VALM, 64'h0);
    step();
    e_in_inst = 1'b1;
    drive(4'h5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'hF, 4'h2);
    expect_val("ins_bad_stat", S_STAT, 64'h4);
    step();
    e_in_inst = 1'b0;

    // call held by stall for three cycles
    drive(4'h8, 1'b0, 64'h100, 64'h40, 4'h4, 4'hF);
    expect_val("call_icode", S_ICODE, 64'h8);
    step();
    m_stall = 1'b1;
    drive(4'h4, 1'b0, 64'h200, 64'h99, 4'h1, 4'h1);
    for (int i = 0; i < 3; i++) begin
      expect_val("stall_icode", S_ICODE, 64'h8);
      expect_val("stall_valE",  S_VALE,  64'h100);
      expect_val("stall_valA",  S_VALA,  64'h40);
      expect_val("stall_dstE",  S_DSTE,  64'h4);
      step();
    end
    m_stall = 1'b0;
    drive(4'h5, 1'b0, 64'h100, 64'h0, 4'hF, 4'h6);
    expect_val("call_mem_valM", S_VALM, 64'h40);
    step();
    drive(4'h5, 1'b0, 64'h108, 64'h0, 4'hF, 4'h6);
    expect_val("call_mem_next", S_VALM, 64'h0);
    step();
    drive(4'h5, 1'b0, 64'h200, 64'h0, 4'hF, 4'h6);
    expect_val("stall_no_write", S_VALM, 64'h0);
    step();

    // Bubble beats stall
    m_stall = 1'b1; m_bubble = 1'b1;
    drive(4'h5, 1'b1, 64'h10, 64'h10, 4'h3, 4'h3);
    expect_val("bub_icode", S_ICODE, 64'h1);
    expect_val("bub_valE",  S_VALE,  64'h0);
    expect_val("bub_dstM",  S_DSTM,  64'hF);
    expect_val("bub_stat",  S_STAT,  64'h1);
    step();
    m_stall = 1'b0; m_bubble = 1'b0;

    // Halted rmmovq with a valid address must not write
    e_hlt = 1'b1;
    drive(4'h4, 1'b0, 64'h180, 64'h55, 4'hF, 4'hF);
    expect_val("hlt_stat", S_STAT, 64'h2);
    step();
    e_hlt = 1'b0;
    drive(4'h5, 1'b0, 64'h180, 64'h0, 4'hF, 4'h7);
    expect_val("hlt_no_write", S_VALM, 64'h0);
    step();

    // Reset clears err and memory
    reset = 1'b1;
    drive(4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
    expect_val("rst2_err", S_ERR, 64'h0);
    step();
    reset = 1'b0;
    drive(4'h5, 1'b0, 64'h100, 64'h0, 4'hF, 4'h3);
    expect_val("rst2_mem", S_VALM, 64'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
